pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
Parametrised, pipelined two-operand adder/subtractor with valid/ready handshakes on input and output. It generalises the single-bit full adder to WIDTH bits. The carry chain is split across STAGES register slices so that wide datapaths meet timing. It sits between operand producers and the ALU/accumulator blocks and supports full backpressure with bubble collapsing.

Parameters:
WIDTH, 16, operand and sum width in bits; must be ≥ 1.
STAGES, 2, number of pipeline register slices; 1 ≤ STAGES ≤ WIDTH; WIDTH % STAGES == 0.
SLICE, WIDTH/STAGES, bits resolved per stage (derived localparam, not overridable).

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat present
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in; used only when sub=0
sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored)
out_valid  output  1  result beat present
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result bits
cout  output  1  carry-out (for sub: 1 = no borrow)
ovf  output  1  two's-complement signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (async assert, sync release): all stage valid flags 0; out_valid=0, sum=0, cout=0, ovf=0; in_ready=0 while rst is high.
- Stage k (0..STAGES-1) resolves bits [k*SLICE +: SLICE] using the carry registered from stage k-1. Stage 0 takes its carry from cin, or 1 when sub=1. B is inverted at entry when sub=1.
- Each stage register holds: valid, resolved low sum bits, carry, unresolved upper A/B bits, and the MSB carry-in needed for ovf.
- Latency: a beat accepted on edge N presents out_valid=1 on the cycle after edge N+STAGES-1, i.e. exactly STAGES cycles when there is no stall.
- Throughput: one beat per cycle when out_ready=1.
- Handshake: a transfer occurs on a rising edge with valid&ready high. Producers must hold a/b/cin/sub stable while in_valid=1 and in_ready=0. sum/cout/ovf are held stable while out_valid=1 and out_ready=0.
- Stage advance rule: stage k loads when stage k is empty OR stage k advances this cycle. The last stage advances when out_ready=1.
- in_ready = stage0_empty OR stage0_advances. This path is combinational from out_ready through the chain; it is acceptable for STAGES ≤ 8.
- Bubble collapsing: an empty stage accepts data even if downstream is stalled.
- Full pipeline + out_ready=0: in_ready=0, no state changes.
- Simultaneous in accept and out drain at full occupancy: both occur, and occupancy is unchanged.
- Overflow: ovf evaluated in the final stage from that stage's MSB carries. With sub=1, ovf flags a signed a-b out of range.
- Wrap-around: sum is modulo 2^WIDTH and cout carries the excess. No saturation.
- Reset mid-operation: in-flight beats are discarded and no partial result is emitted.
- STAGES=1: a single registered adder with latency 1.

Decomposition:
- Shared package adder_pkg: op encoding constants OP_ADD=1'b0, OP_SUB=1'b1; a function computing SLICE and checking the legality of WIDTH/STAGES.
- Elaboration-time assertion fires if WIDTH % STAGES != 0.
- One sub-module, adder_slice: combinational SLICE-bit ripple segment (ai, bi, ci -> si, co, c_msb_in) built from full-adder cells.
- The top instantiates STAGES slices plus the handshake registers.

Test Plan:
All scenarios use WIDTH=8, STAGES=2.
- Basic add: a=0x35, b=0x4A, cin=1, sub=0, out_ready=1 -> 2 cycles later sum=0x80, cout=0, ovf=1.
- Subtract with borrow: a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0, ovf=0. Then a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Wrap-around: a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, ovf=0.
- Streaming: 16 back-to-back beats of random a/b with out_ready=1 -> 16 results in order, one per cycle, first after 2 cycles, all matching the reference model.
- Backpressure: out_ready=0 for 5 cycles while feeding beats -> exactly 2 beats accepted, then in_ready=0. The held result does not change. out_ready=1 -> beats drain in order with none lost or duplicated.
- Reset mid-flight: assert rst asynchronously (between edges) with 2 beats in flight -> out_valid=0 and sum=0 immediately. After release, the first new beat emerges with the correct result and no stale output.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder: operation encoding and
// configuration helpers used at elaboration time.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic bit cfg_legal(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // An illegal configuration still yields a usable slice width so the
  // elaboration check below reports it instead of a cascade of range errors.
  function automatic int calc_slice(input int width, input int stages);
    if (cfg_legal(width, stages)) begin
      return width / stages;
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// Combinational ripple-carry segment built from full-adder cells; reports the
// carry into its top bit so the final segment can derive signed overflow.
module adder_slice
  import adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] ai,
  input  logic [W-1:0] bi,
  input  logic         ci,
  output logic [W-1:0] si,
  output logic         co,
  output logic         c_msb_in
);

  logic [W:0] c_s;

  // Full-adder chain
  always_comb begin
    c_s    = '0;
    si     = '0;
    c_s[0] = ci;
    for (int i = 0; i < W; i++) begin
      si[i]    = ai[i] ^ bi[i] ^ c_s[i];
      c_s[i+1] = (ai[i] & bi[i]) | (c_s[i] & (ai[i] ^ bi[i]));
    end
  end

  assign co       = c_s[W];
  assign c_msb_in = c_s[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES
// registered slices with valid/ready flow control and bubble collapsing.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = calc_slice(WIDTH, STAGES);

  if (!cfg_legal(WIDTH, STAGES)) begin : g_cfg_check
    $error("pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  logic [WIDTH-1:0]  b_eff_s;
  logic              c0_s;
  logic [STAGES-1:0] vld_s;
  logic [STAGES-1:0] ld_s;
  logic              ovf_q;

  assign b_eff_s = (sub == OP_SUB) ? ~b : b;
  assign c0_s    = (sub == OP_SUB) ? 1'b1 : cin;

  // A stage loads when it is empty or its content moves on; walk from the output back.
  always_comb begin : p_advance
    logic rdy_s;
    ld_s  = '0;
    rdy_s = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld_s[k] = ~vld_s[k] | rdy_s;
      rdy_s   = ld_s[k];
    end
  end

  assign in_ready = ld_s[0] & ~rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RW = (k + 1) * SLICE;
    localparam int UW = WIDTH - RW;

    logic [SLICE-1:0] ai_s, bi_s, si_s;
    logic             ci_s, co_s, vin_s;
    logic [RW-1:0]    sum_d, sum_q;
    logic             valid_q, carry_q;

    if (k == 0) begin : g_in
      assign ai_s  = a[SLICE-1:0];
      assign bi_s  = b_eff_s[SLICE-1:0];
      assign ci_s  = c0_s;
      assign vin_s = in_valid;
      assign sum_d = si_s;
    end else begin : g_in
      assign ai_s  = g_st[k-1].g_up.a_q[SLICE-1:0];
      assign bi_s  = g_st[k-1].g_up.b_q[SLICE-1:0];
      assign ci_s  = g_st[k-1].carry_q;
      assign vin_s = g_st[k-1].valid_q;
      assign sum_d = {si_s, g_st[k-1].sum_q};
    end

    // Unresolved operand bits travel right-aligned so the next slice reads the bottom.
    if (UW > 0) begin : g_up
      logic [UW-1:0] a_d, b_d, a_q, b_q;

      if (k == 0) begin : g_src
        assign a_d = a[WIDTH-1:SLICE];
        assign b_d = b_eff_s[WIDTH-1:SLICE];
      end else begin : g_src
        assign a_d = g_st[k-1].g_up.a_q[UW+SLICE-1:SLICE];
        assign b_d = g_st[k-1].g_up.b_q[UW+SLICE-1:SLICE];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld_s[k]) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_fa
      logic cmsb_s;

      adder_slice #(.W(SLICE)) u_slice (
        .ai       (ai_s),
        .bi       (bi_s),
        .ci       (ci_s),
        .si       (si_s),
        .co       (co_s),
        .c_msb_in (cmsb_s)
      );

      // Signed overflow: carry into the MSB disagrees with carry out of it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (ld_s[k]) begin
          ovf_q <= co_s ^ cmsb_s;
        end
      end
    end else begin : g_fa
      logic unused_cmsb_s;

      adder_slice #(.W(SLICE)) u_slice (
        .ai       (ai_s),
        .bi       (bi_s),
        .ci       (ci_s),
        .si       (si_s),
        .co       (co_s),
        .c_msb_in (unused_cmsb_s)
      );
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else if (ld_s[k]) begin
        valid_q <= vin_s;
        sum_q   <= sum_d;
        carry_q <= co_s;
      end
    end

    assign vld_s[k] = valid_q;
  end

  assign out_valid = g_st[STAGES-1].valid_q;
  assign sum       = g_st[STAGES-1].sum_q;
  assign cout      = g_st[STAGES-1].carry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=8, STAGES=2): directed vector
// table, random streaming against an arithmetic reference, stall and reset cases.
module tb_pipelined_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t     sb_q[$];
  int       total = 0;
  int       bad = 0;
  int       cyc = 0;
  int       n_out = 0;
  bit       lat_chk = 1'b0;
  vec_t     vt[8];
  int       n0, acc;
  bit       acc_now, held_seen;
  logic [W-1:0] held;

  pipelined_adder #(.WIDTH(W), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                 input logic cin_i, input logic sub_i);
    exp_t r;
    int   u, sr;
    int   sa, sb;
    sa = int'($signed(a_i));
    sb = int'($signed(b_i));
    if (sub_i) begin
      u      = int'(a_i) - int'(b_i);
      r.sum  = 8'(u);
      r.cout = (a_i >= b_i);
      sr     = sa - sb;
    end else begin
      u      = int'(a_i) + int'(b_i) + int'(cin_i);
      r.sum  = 8'(u);
      r.cout = (u > 255);
      sr     = sa + sb + int'(cin_i);
    end
    r.ovf = (sr > 127) || (sr < -128);
    r.cyc = 0;
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Scoreboard: record accepted beats and match every emitted result in order.
  initial begin : scoreboard
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("sb_unexpected_out", 32'(out_valid), 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("sb_sum", 32'(sum), 32'(e.sum));
            check("sb_cout", 32'(cout), 32'(e.cout));
            check("sb_ovf", 32'(ovf), 32'(e.ovf));
            if (lat_chk) check("sb_latency", 32'(cyc - e.cyc), 32'd2);
            n_out++;
          end
        end
        if (in_valid && in_ready) begin
          e     = model(a, b, cin, sub);
          e.cyc = cyc;
          sb_q.push_back(e);
        end
      end
    end
  end

  task automatic apply_vec(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, 32'(sum), 32'(v.sum));
    check({tag, "_cout"}, 32'(cout), 32'(v.cout));
    check({tag, "_ovf"}, 32'(ovf), 32'(v.ovf));
  endtask

  task automatic wait_drain(input int bound, input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic rand_beat();
    a   = 8'($urandom_range(0, 255));
    b   = 8'($urandom_range(0, 255));
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    vt[0] = '{a: 8'h35, b: 8'h4A, cin: 1'b1, sub: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vt[1] = '{a: 8'h10, b: 8'h20, cin: 1'b0, sub: 1'b1, sum: 8'hF0, cout: 1'b0, ovf: 1'b0};
    vt[2] = '{a: 8'h80, b: 8'h01, cin: 1'b0, sub: 1'b1, sum: 8'h7F, cout: 1'b1, ovf: 1'b1};
    vt[3] = '{a: 8'hFF, b: 8'h01, cin: 1'b1, sub: 1'b0, sum: 8'h01, cout: 1'b1, ovf: 1'b0};
    vt[4] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sub: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vt[5] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sub: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vt[6] = '{a: 8'h05, b: 8'h03, cin: 1'b1, sub: 1'b1, sum: 8'h02, cout: 1'b1, ovf: 1'b0};
    vt[7] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sub: 1'b0, sum: 8'h10, cout: 1'b0, ovf: 1'b0};

    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);

    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apply_vec(vt[i], $sformatf("vec%0d", i));
    end

    // Back-to-back random stream with no stalls.
    n0 = n_out;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      rand_beat();
      in_valid = 1'b1;
      @(negedge clk);
      check("stream_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_drain(10, "stream");
    check("stream_count", 32'(n_out - n0), 32'd16);
    lat_chk = 1'b0;

    // Backpressure: only two beats fit, then the held result must stay put.
    n0 = n_out;
    acc = 0;
    held_seen = 1'b0;
    held = '0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    rand_beat();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      acc_now = in_ready;
      if (acc_now) acc++;
      if (out_valid && !held_seen) begin
        held_seen = 1'b1;
        held = sum;
      end
      @(posedge clk);
      #1;
      if (acc_now) rand_beat();
    end
    @(negedge clk);
    check("bp_accepts", 32'(acc), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_held_sum", 32'(sum), 32'(held));
    check("bp_queue_depth", 32'(sb_q.size()), 32'd2);
    if (sb_q.size() > 0) check("bp_held_model", 32'(sum), 32'(sb_q[0].sum));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain(10, "bp");
    check("bp_count", 32'(n_out - n0), 32'd2);

    // Reset between edges with two beats in flight.
    @(posedge clk);
    #1;
    a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 8'h40; b = 8'h05;
    @(posedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_no_stale", 32'(out_valid), 32'd0);
    lat_chk = 1'b1;
    apply_vec('{a: 8'h12, b: 8'h34, cin: 1'b0, sub: 1'b0, sum: 8'h46, cout: 1'b0, ovf: 1'b0}, "post_rst");
    wait_drain(10, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
